led_sweep_seq: RTL

LED sweep sequencer that sits directly downstream of the rate counter and consumes its `o_valid` tick. It advances an NB_LEDS-wide one-hot or flash pattern by one step per tick. It supports four sweep modes: rotate left, rotate right, ping-pong (the third sweep), and flash-all. It drives the board LEDs directly.

---
 rtl/led_sweep_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/led_sweep_seq.sv
// LED sweep sequencer: advances a rotate / ping-pong / flash pattern by one
// step on each rising edge of the upstream rate-counter tick.
module led_sweep_seq #(
    parameter int NB_LEDS = 4,
    parameter int NB_MODE = 2
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_MODE-1:0] i_mode,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_dir,
    output logic               o_step
);

    typedef enum logic [1:0] {
        MODE_ROL   = 2'b00,
        MODE_ROR   = 2'b01,
        MODE_PING  = 2'b10,
        MODE_FLASH = 2'b11
    } mode_e;

    localparam logic [NB_LEDS-1:0] LED_LSB = NB_LEDS'(1);
    localparam logic [NB_LEDS-1:0] LED_MSB = {1'b1, {(NB_LEDS-1){1'b0}}};

    mode_e              r_mode;
    logic               r_valid_d;
    logic [NB_LEDS-1:0] r_led;
    logic               r_dir;
    logic               r_step;

    mode_e              w_mode_in;
    mode_e              w_mode_nxt;
    logic               w_step;
    logic [NB_LEDS-1:0] w_led_nxt;
    logic               w_dir_nxt;
    logic               w_step_nxt;

    assign w_mode_in = mode_e'(i_mode[1:0]);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_mode    <= MODE_ROL;
            r_valid_d <= 1'b0;
            r_led     <= LED_LSB;
            r_dir     <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_valid_d <= i_valid;
            r_led     <= w_led_nxt;
            r_dir     <= w_dir_nxt;
            r_step    <= w_step_nxt;
        end
    end

    always_comb begin
        w_step     = i_valid & ~r_valid_d;
        w_mode_nxt = r_mode;
        w_led_nxt  = r_led;
        w_dir_nxt  = r_dir;
        w_step_nxt = 1'b0;

        // A mode change reseeds the pattern and swallows any coincident step.
        if (w_mode_in != r_mode) begin
            w_mode_nxt = w_mode_in;
            unique case (w_mode_in)
                MODE_ROL:   w_led_nxt = LED_LSB;
                MODE_ROR:   w_led_nxt = LED_MSB;
                MODE_PING: begin
                    w_led_nxt = LED_LSB;
                    w_dir_nxt = 1'b0;
                end
                MODE_FLASH: w_led_nxt = '0;
            endcase
        end else if (w_step) begin
            w_step_nxt = 1'b1;
            unique case (r_mode)
                MODE_ROL: begin
                    if (r_led == '0)
                        w_led_nxt = LED_LSB;
                    else
                        w_led_nxt = {r_led[NB_LEDS-2:0], r_led[NB_LEDS-1]};
                end
                MODE_ROR: begin
                    if (r_led == '0)
                        w_led_nxt = LED_MSB;
                    else
                        w_led_nxt = {r_led[0], r_led[NB_LEDS-1:1]};
                end
                MODE_PING: begin
                    if (r_led == '0) begin
                        w_led_nxt = LED_LSB;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_led_nxt = r_dir ? (r_led >> 1) : (r_led << 1);
                        // Reverse on reaching an endpoint so it is lit only once.
                        if (w_led_nxt[NB_LEDS-1])
                            w_dir_nxt = 1'b1;
                        else if (w_led_nxt[0])
                            w_dir_nxt = 1'b0;
                    end
                end
                MODE_FLASH: w_led_nxt = ~r_led;
            endcase
        end
    end

    assign o_led  = r_led;
    assign o_dir  = r_dir;
    assign o_step = r_step;

endmodule
